// File: rtl/junction_pkg.sv
// Shared types and default phase durations for the two-road junction sequencer.
package junction_pkg;

  typedef enum logic [3:0] {
    S_MAJ_GREEN,
    S_MAJ_AMBER,
    S_ALL_RED_A,
    S_MIN_RED_AMBER,
    S_MIN_GREEN,
    S_MIN_AMBER,
    S_ALL_RED_B,
    S_WALK,
    S_MAJ_RED_AMBER
  } state_t;

  typedef enum logic {SERVED_CAR, SERVED_PED} served_t;

  localparam int unsigned DEF_T_MAJ_GREEN = 8;
  localparam int unsigned DEF_T_AMBER     = 3;
  localparam int unsigned DEF_T_ALL_RED   = 2;
  localparam int unsigned DEF_T_RED_AMBER = 2;
  localparam int unsigned DEF_T_MIN_GREEN = 6;
  localparam int unsigned DEF_T_WALK      = 5;

  function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/junction_controller_phase_timer.sv
// Loadable down-counter that saturates at zero; expired flags the zero count.
module phase_timer #(
  parameter int unsigned           WIDTH       = 3,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      count_q <= RESET_VALUE;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/junction_controller.sv
// Junction sequencer: major road rests on green, minor cars and pedestrians
// are latched and served in turn, with every phase held for its duration.
//
// state           | meaning
// S_MAJ_GREEN     | major green, rest state, leaves after minimum when a request waits
// S_MAJ_AMBER     | major amber
// S_ALL_RED_A     | clearance before serving, arbitration on expiry
// S_MIN_RED_AMBER | minor red+amber
// S_MIN_GREEN     | minor green, car request cleared on entry
// S_MIN_AMBER     | minor amber
// S_ALL_RED_B     | clearance after minor green
// S_WALK          | pedestrian walk, both heads red
// S_MAJ_RED_AMBER | major red+amber before returning to green
module junction_controller
  import junction_pkg::*;
#(
  parameter int unsigned T_MAJ_GREEN = DEF_T_MAJ_GREEN,
  parameter int unsigned T_AMBER     = DEF_T_AMBER,
  parameter int unsigned T_ALL_RED   = DEF_T_ALL_RED,
  parameter int unsigned T_RED_AMBER = DEF_T_RED_AMBER,
  parameter int unsigned T_MIN_GREEN = DEF_T_MIN_GREEN,
  parameter int unsigned T_WALK      = DEF_T_WALK
) (
  input  logic clock,
  input  logic nreset,
  input  logic MINOR_CAR,
  input  logic PED_BUTTON,
  output logic MAJ_GREEN,
  output logic MAJ_AMBER,
  output logic MAJ_RED,
  output logic MIN_GREEN,
  output logic MIN_AMBER,
  output logic MIN_RED,
  output logic WALK,
  output logic CAR_PENDING,
  output logic PED_PENDING
);

  localparam int unsigned T_MAX = max_of(max_of(max_of(T_MAJ_GREEN, T_AMBER), max_of(T_ALL_RED, T_RED_AMBER)),
                                         max_of(T_MIN_GREEN, T_WALK));
  localparam int unsigned TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  if (T_MAJ_GREEN < 1 || T_AMBER < 1 || T_ALL_RED < 1 ||
      T_RED_AMBER < 1 || T_MIN_GREEN < 1 || T_WALK < 1) begin : g_bad_timing
    $error("junction_controller: every phase duration must be at least 1");
  end

  state_t  state_q, state_d;
  served_t last_q, last_d;
  logic    car_q, car_d, ped_q, ped_d;
  logic    expired, load;
  logic [TW-1:0] load_value;

  function automatic logic [TW-1:0] phase_len_m1(input state_t s);
    int unsigned t;
    case (s)
      S_MAJ_AMBER, S_MIN_AMBER:         t = T_AMBER;
      S_ALL_RED_A, S_ALL_RED_B:         t = T_ALL_RED;
      S_MIN_RED_AMBER, S_MAJ_RED_AMBER: t = T_RED_AMBER;
      S_MIN_GREEN:                      t = T_MIN_GREEN;
      S_WALK:                           t = T_WALK;
      default:                          t = T_MAJ_GREEN;
    endcase
    return TW'(t - 1);
  endfunction

  phase_timer #(
    .WIDTH       (TW),
    .RESET_VALUE (TW'(T_MAJ_GREEN - 1))
  ) u_timer (
    .clock      (clock),
    .nreset     (nreset),
    .load       (load),
    .load_value (load_value),
    .expired    (expired)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      S_MAJ_GREEN:     if (expired && (car_q || ped_q)) state_d = S_MAJ_AMBER;
      S_MAJ_AMBER:     if (expired) state_d = S_ALL_RED_A;
      S_ALL_RED_A: begin
        if (expired) begin
          // On a tie the requester not served last wins.
          if (car_q && (!ped_q || last_q == SERVED_PED)) begin
            state_d = S_MIN_RED_AMBER;
            last_d  = SERVED_CAR;
          end else if (ped_q) begin
            state_d = S_WALK;
            last_d  = SERVED_PED;
          end else begin
            state_d = S_MAJ_RED_AMBER;
          end
        end
      end
      S_MIN_RED_AMBER: if (expired) state_d = S_MIN_GREEN;
      S_MIN_GREEN:     if (expired) state_d = S_MIN_AMBER;
      S_MIN_AMBER:     if (expired) state_d = S_ALL_RED_B;
      S_ALL_RED_B:     if (expired) state_d = S_MAJ_RED_AMBER;
      S_WALK:          if (expired) state_d = S_MAJ_RED_AMBER;
      S_MAJ_RED_AMBER: if (expired) state_d = S_MAJ_GREEN;
      default:         state_d = S_MAJ_GREEN;
    endcase

    load       = (state_d != state_q);
    load_value = phase_len_m1(state_d);

    car_d = car_q;
    if (state_d == S_MIN_GREEN && state_q != S_MIN_GREEN) car_d = 1'b0;
    else if (MINOR_CAR && state_q != S_MIN_GREEN)         car_d = 1'b1;

    ped_d = ped_q;
    if (state_d == S_WALK && state_q != S_WALK)   ped_d = 1'b0;
    else if (PED_BUTTON && state_q != S_WALK)     ped_d = 1'b1;
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q <= S_MAJ_GREEN;
      last_q  <= SERVED_PED;
      car_q   <= 1'b0;
      ped_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      car_q   <= car_d;
      ped_q   <= ped_d;
    end
  end

  always_comb begin
    {MAJ_GREEN, MAJ_AMBER, MAJ_RED, MIN_GREEN, MIN_AMBER, MIN_RED, WALK} = 7'b0;
    case (state_q)
      S_MAJ_GREEN:     {MAJ_GREEN, MIN_RED} = 2'b11;
      S_MAJ_AMBER:     {MAJ_AMBER, MIN_RED} = 2'b11;
      S_MIN_RED_AMBER: {MAJ_RED, MIN_RED, MIN_AMBER} = 3'b111;
      S_MIN_GREEN:     {MAJ_RED, MIN_GREEN} = 2'b11;
      S_MIN_AMBER:     {MAJ_RED, MIN_AMBER} = 2'b11;
      S_WALK:          {MAJ_RED, MIN_RED, WALK} = 3'b111;
      S_MAJ_RED_AMBER: {MAJ_RED, MAJ_AMBER, MIN_RED} = 3'b111;
      default:         {MAJ_RED, MIN_RED} = 2'b11;
    endcase
  end

  assign CAR_PENDING = car_q;
  assign PED_PENDING = ped_q;

endmodule
